pipe_out_streamer: RTL and testbench

//  FPGA-to-host transmit path for the Opal Kelly pipe interface: fabric logic pushes 32-bit words,
//  the block buffers them and serves them to an okBTPipeOut endpoint in fixed-size blocks.

---
 rtl/pipe_out_streamer.sv | 149 ++++++++++++++
 tb/tb_pipe_out_streamer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_out_streamer.sv
// Buffered FPGA-to-host word streamer feeding an okBTPipeOut endpoint in fixed blocks.
// Optional macro PIPE_OUT_STREAMER_CNT_EN enables the delivered-word counter tx_count.
module pipe_out_streamer #(
   parameter int DEPTH_LOG2  = 10,
   parameter int BLOCK_WORDS = 256
) (
   input  logic                  okClk,
   input  logic                  rst,
   input  logic [31:0]           src_data,
   input  logic                  src_valid,
   output logic                  src_ready,
   output logic [31:0]           ep_datain,
   input  logic                  ep_read,
   output logic                  ep_ready,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   output logic                  underflow,
   output logic [31:0]           tx_count
);

   localparam int CW = $clog2(BLOCK_WORDS) + 1;
   localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0] BLK  = (DEPTH_LOG2 + 1)'(BLOCK_WORDS);
   localparam logic [CW-1:0]       LAST = CW'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      XFER
   } state_t;

   state_t state, state_next;
   logic [CW-1:0] cnt, cnt_next;

   logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
   logic [DEPTH_LOG2-1:0] wptr, rptr, rnext;
   logic push, pop, empty;

   assign empty     = (level == '0);
   assign src_ready = (level != FULL);
   assign push      = src_valid && src_ready;
   assign pop       = ep_read && !empty;
   assign rnext     = rptr + 1'b1;

   // Storage array, no reset so it maps onto block RAM
   always_ff @(posedge okClk) begin
      if (push) mem[wptr] <= src_data;
   end

   // Pointers, fill level and sticky error flags
   always_ff @(posedge okClk) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rnext;
         unique case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (src_valid && !src_ready) overflow <= 1'b1;
         if (ep_read && empty) underflow <= 1'b1;
      end
   end

   // Prefetch register: always holds the FIFO head, bypassing RAM when the head is being written
   always_ff @(posedge okClk) begin
      if (rst) begin
         ep_datain <= '0;
      end else if (pop) begin
         if (level == ONE) begin
            if (push) ep_datain <= src_data;
         end else begin
            ep_datain <= mem[rnext];
         end
      end else if (push && empty) begin
         ep_datain <= src_data;
      end
   end

   // Block FSM state, word counter and registered ep_ready
   always_ff @(posedge okClk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         ep_ready <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         ep_ready <= (state_next == ARMED);
      end
   end

   // Block FSM next-state: arm on a full block, count the block's reads
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      unique case (state)
         IDLE: begin
            if (level >= BLK) state_next = ARMED;
         end
         ARMED: begin
            if (ep_read) begin
               if (LAST == '0) begin
                  state_next = IDLE;
               end else begin
                  state_next = XFER;
                  cnt_next   = CW'(1);
               end
            end
         end
         XFER: begin
            if (ep_read) begin
               if (cnt == LAST) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

`ifdef PIPE_OUT_STREAMER_CNT_EN
   logic [31:0] tx_q;

   // Count every word actually handed to the host
   always_ff @(posedge okClk) begin
      if (rst) tx_q <= '0;
      else if (pop) tx_q <= tx_q + 32'd1;
   end

   assign tx_count = tx_q;
`else
   assign tx_count = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_out_streamer.sv
// Directed testbench for pipe_out_streamer (DEPTH_LOG2=10, BLOCK_WORDS=256).
// Checks tx_count against the counter model only when PIPE_OUT_STREAMER_CNT_EN is defined.
module tb_pipe_out_streamer;

   logic        okClk = 1'b0;
   logic        rst;
   logic [31:0] src_data;
   logic        src_valid;
   logic        src_ready;
   logic [31:0] ep_datain;
   logic        ep_read;
   logic        ep_ready;
   logic [10:0] level;
   logic        overflow;
   logic        underflow;
   logic [31:0] tx_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_tx = 0;

   pipe_out_streamer #(
      .DEPTH_LOG2(10),
      .BLOCK_WORDS(256)
   ) dut (
      .okClk(okClk),
      .rst(rst),
      .src_data(src_data),
      .src_valid(src_valid),
      .src_ready(src_ready),
      .ep_datain(ep_datain),
      .ep_read(ep_read),
      .ep_ready(ep_ready),
      .level(level),
      .overflow(overflow),
      .underflow(underflow),
      .tx_count(tx_count)
   );

   always #5 okClk = ~okClk;

   initial begin
      #2ms;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge okClk);
      #1;
   endtask

   task automatic check_tx(input string name);
      checks++;
`ifdef PIPE_OUT_STREAMER_CNT_EN
      if (tx_count !== exp_tx) begin
         errors++;
         $display("FAIL %s tx_count got %0d want %0d", name, tx_count, exp_tx);
      end
`else
      if (tx_count !== 32'h0) begin
         errors++;
         $display("FAIL %s tx_count got %0d want 0", name, tx_count);
      end
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      src_valid = 1'b0;
      src_data = '0;
      ep_read = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      checks++;
      if (level !== 11'd0) begin
         errors++;
         $display("FAIL reset_level got %0d want 0", level);
      end
      checks++;
      if (src_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_src_ready got %b want 1", src_ready);
      end
      checks++;
      if (ep_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ep_ready got %b want 0", ep_ready);
      end
      checks++;
      if (ep_datain !== 32'h0) begin
         errors++;
         $display("FAIL reset_datain got %h want 0", ep_datain);
      end
      checks++;
      if ({overflow, underflow} !== 2'b00) begin
         errors++;
         $display("FAIL reset_flags got %b want 00", {overflow, underflow});
      end
      exp_tx = 0;
      check_tx("reset");
   endtask

   task automatic read_block(input string name, input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         checks++;
         if (ep_datain !== base + i) begin
            errors++;
            $display("FAIL %s_data[%0d] got %h want %h", name, i, ep_datain, base + i);
         end
         ep_read = 1'b1;
         step();
         exp_tx++;
         checks++;
         if (ep_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_low[%0d] got %b want 0", name, i, ep_ready);
         end
      end
      ep_read = 1'b0;
   endtask

   task automatic test_block();
      for (int i = 0; i < 256; i++) begin
         src_valid = 1'b1;
         src_data = i;
         step();
      end
      src_valid = 1'b0;
      checks++;
      if (level !== 11'd256 || ep_ready !== 1'b0) begin
         errors++;
         $display("FAIL blk_arm_edge got level %0d ready %b want 256 0", level, ep_ready);
      end
      step();
      checks++;
      if (ep_ready !== 1'b1) begin
         errors++;
         $display("FAIL blk_ready got %b want 1", ep_ready);
      end
      read_block("blk", 256, 32'd0);
      step();
      checks++;
      if (level !== 11'd0 || ep_ready !== 1'b0) begin
         errors++;
         $display("FAIL blk_done got level %0d ready %b want 0 0", level, ep_ready);
      end
      check_tx("blk");
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 1024; i++) begin
         src_valid = 1'b1;
         src_data = 1000 + i;
         step();
      end
      checks++;
      if (level !== 11'd1024 || src_ready !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_full got level %0d rdy %b ovf %b want 1024 0 0",
                  level, src_ready, overflow);
      end
      src_data = 32'hDEAD_BEEF;
      step();
      src_valid = 1'b0;
      checks++;
      if (overflow !== 1'b1 || level !== 11'd1024) begin
         errors++;
         $display("FAIL ovf_set got ovf %b level %0d want 1 1024", overflow, level);
      end
      checks++;
      if (ep_datain !== 32'd1000) begin
         errors++;
         $display("FAIL ovf_head got %0d want 1000", ep_datain);
      end
      ep_read = 1'b1;
      step();
      ep_read = 1'b0;
      exp_tx++;
      checks++;
      if (src_ready !== 1'b1 || level !== 11'd1023) begin
         errors++;
         $display("FAIL ovf_pop got rdy %b level %0d want 1 1023", src_ready, level);
      end
      for (int i = 1; i < 1024; i++) begin
         checks++;
         if (ep_datain !== 32'd1000 + i) begin
            errors++;
            $display("FAIL drain[%0d] got %0d want %0d", i, ep_datain, 1000 + i);
         end
         ep_read = 1'b1;
         step();
         exp_tx++;
      end
      ep_read = 1'b0;
      step();
      checks++;
      if (level !== 11'd0 || ep_ready !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL drain_end got level %0d rdy %b udf %b want 0 0 0",
                  level, ep_ready, underflow);
      end
      check_tx("drain");
   endtask

   task automatic test_push_pop_level1();
      src_valid = 1'b1;
      src_data = 32'hA5A5_A5A5;
      step();
      checks++;
      if (level !== 11'd1 || ep_datain !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL l1_head got level %0d data %h want 1 a5a5a5a5", level, ep_datain);
      end
      src_data = 32'h1234_5678;
      ep_read = 1'b1;
      step();
      src_valid = 1'b0;
      ep_read = 1'b0;
      exp_tx++;
      checks++;
      if (level !== 11'd1 || ep_datain !== 32'h1234_5678) begin
         errors++;
         $display("FAIL l1_pushpop got level %0d data %h want 1 12345678", level, ep_datain);
      end
      ep_read = 1'b1;
      step();
      ep_read = 1'b0;
      exp_tx++;
      checks++;
      if (level !== 11'd0) begin
         errors++;
         $display("FAIL l1_empty got level %0d want 0", level);
      end
      check_tx("l1");
   endtask

   task automatic test_underflow();
      ep_read = 1'b1;
      step();
      ep_read = 1'b0;
      checks++;
      if (underflow !== 1'b1 || level !== 11'd0) begin
         errors++;
         $display("FAIL udf got udf %b level %0d want 1 0", underflow, level);
      end
      checks++;
      if (ep_datain !== 32'h1234_5678) begin
         errors++;
         $display("FAIL udf_hold got %h want 12345678", ep_datain);
      end
      check_tx("udf");
   endtask

   task automatic test_reset_mid_block();
      for (int i = 0; i < 512; i++) begin
         src_valid = 1'b1;
         src_data = 2000 + i;
         step();
      end
      src_valid = 1'b0;
      step();
      checks++;
      if (ep_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_armed got %b want 1", ep_ready);
      end
      for (int i = 0; i < 100; i++) begin
         ep_read = 1'b1;
         step();
      end
      ep_read = 1'b0;
      checks++;
      if (ep_datain !== 32'd2100 || ep_ready !== 1'b0 || level !== 11'd412) begin
         errors++;
         $display("FAIL mid_state got data %0d rdy %b level %0d want 2100 0 412",
                  ep_datain, ep_ready, level);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_tx = 0;
      checks++;
      if (level !== 11'd0 || ep_ready !== 1'b0 || underflow !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst got level %0d rdy %b flags %b want 0 0 00",
                  level, ep_ready, {overflow, underflow});
      end
      check_tx("mid_rst");
      for (int i = 0; i < 256; i++) begin
         src_valid = 1'b1;
         src_data = 3000 + i;
         step();
      end
      src_valid = 1'b0;
      step();
      checks++;
      if (ep_ready !== 1'b1) begin
         errors++;
         $display("FAIL refill_ready got %b want 1", ep_ready);
      end
      read_block("refill", 256, 32'd3000);
      step();
      checks++;
      if (level !== 11'd0 || ep_ready !== 1'b0) begin
         errors++;
         $display("FAIL refill_done got level %0d rdy %b want 0 0", level, ep_ready);
      end
      check_tx("refill");
   endtask

   initial begin
      test_reset();
      test_block();
      test_overflow();
      test_push_pop_level1();
      test_underflow();
      test_reset_mid_block();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
